cmac_lbus_rx_sf: RTL
====================

Name: cmac_lbus_rx_sf

Overview:
Parametrised store-and-forward converter from the CMAC segmented RX LBUS to AXI4-Stream. It replaces the fixed 4-segment LBUS-to-AXI path with a configurable segment count, adds frame-level buffering, drops overflowed frames and optionally errored ones, and attaches the SOP timestamp to every beat. It sits between the CMAC wrapper RX LBUS and the user RX stream, in the CMAC RX user-clock domain.

Parameters:
NUM_SEG, 4, number of 128-bit LBUS segments; AXI data width is NUM_SEG*128
FIFO_DEPTH, 64, beat buffer depth; power of two, at least 4
TS_W, 80, timestamp width
DROP_ERR, 1, 1 = drop frames with err at EOP; 0 = forward them with tuser_err=1 on the tlast beat

Ports:
CLK  in  1  RX user clock
RST_N  in  1  asynchronous active-low reset
lbus_en  in  NUM_SEG  segment enable
lbus_sop  in  NUM_SEG  start of packet
lbus_eop  in  NUM_SEG  end of packet
lbus_err  in  NUM_SEG  frame error; valid with eop
lbus_mty  in  NUM_SEG*4  empty bytes; valid with eop
lbus_data  in  NUM_SEG*128  segment data; segment MSB is the first byte
rx_timestamp  in  TS_W  timestamp, sampled on the SOP cycle
m_axis_tvalid  out  1  AXI valid
m_axis_tready  in  1  AXI ready
m_axis_tdata  out  NUM_SEG*128  AXI data; byte 0 is the first byte
m_axis_tkeep  out  NUM_SEG*16  byte enables
m_axis_tlast  out  1  last beat of frame
m_axis_tuser_err  out  1  errored frame (DROP_ERR=0 only), on the tlast beat
m_axis_tuser_ts  out  TS_W  frame SOP timestamp, on every beat
clr_cnt  in  1  synchronous counter clear
cnt_frames  out  32  committed frames, saturating
cnt_drop_err  out  32  frames dropped for err or protocol, saturating
cnt_drop_ovf  out  32  frames dropped for overflow, saturating
fifo_level  out  $clog2(FIFO_DEPTH)+1  committed beats not yet read

Behaviour:
- Input contract: SOP only in segment 0; enabled segments are contiguous from segment 0; at most one EOP per cycle, in the highest enabled segment. A cycle with lbus_en[0]=0 is idle.
- Byte mapping: AXI byte k = segment k/16, bits [127-8*(k%16) -: 8].
- tkeep: all ones on non-last beats. On the last beat, only the bytes below (eop_seg*16 + 16 - mty) are set.
- Buffer pointers: wr_ptr (speculative), commit_ptr, rd_ptr. Each is $clog2(FIFO_DEPTH)+1 bits and wraps naturally.
- Full condition: wr_ptr - rd_ptr == FIFO_DEPTH.
- Each buffer entry holds data, keep, last, err and the SOP timestamp.
- FSM states: IDLE, RECV, DISCARD.
- IDLE: en[0]&sop[0] samples rx_timestamp and writes the beat. If eop is in the same cycle, finish the frame and stay in IDLE; otherwise go to RECV. en without sop is ignored.
- RECV: each enabled cycle writes one beat.
  - eop: finish the frame, go to IDLE.
  - sop seen in RECV: roll back wr_ptr to commit_ptr, cnt_drop_err++, then treat this cycle as a new SOP from IDLE.
- Finish frame:
  - err=1 and DROP_ERR=1: wr_ptr <= commit_ptr, cnt_drop_err++.
  - Otherwise: commit_ptr <= wr_ptr (including this beat), cnt_frames++.
- Overflow: a beat arrives while full, in IDLE or RECV. Then wr_ptr <= commit_ptr and cnt_drop_ovf++. If the beat has no eop go to DISCARD; otherwise go to IDLE. Frames longer than FIFO_DEPTH beats are therefore always dropped.
- DISCARD: ignore beats until eop, then go to IDLE. A sop seen in DISCARD starts a new frame as from IDLE.
- Read side: a single output register stage.
  - Loads when rd_ptr != commit_ptr and (tvalid=0 or tready=1).
  - Output holds stable while tvalid&!tready.
- Latency: EOP in cycle t gives the first beat tvalid in cycle t+2 at the earliest. Afterwards, 1 beat/cycle with tready=1.
- Simultaneous events:
  - Read and write/commit in the same cycle are both honoured.
  - Full is evaluated against the pre-read rd_ptr.
  - clr_cnt wins over an increment in the same cycle.
  - Counters saturate at 0xFFFFFFFF.
- fifo_level = commit_ptr - rd_ptr; it excludes the output register.
- Reset (async, any time, including mid-frame):
  - All pointers 0, FSM to IDLE, counters 0, fifo_level 0.
  - All m_axis outputs 0.
  - Any partial frame is lost.

Test Plan:
- NUM_SEG=4, tready=1: 64-byte frame (EOP in seg3, mty=0) sent at t -> 1 beat at t+2, tkeep=all ones, tlast=1, bytes in order, ts = SOP value, cnt_frames=1.
- 150-byte frame (beats 64, 64, 22; last EOP seg1, mty=10) -> 3 beats, last tkeep=0x3FFFFF, tlast only on beat 3.
- DROP_ERR=1, frame with err at EOP -> no output, cnt_drop_err=1; DROP_ERR=0 -> frame output with tuser_err=1 on tlast only.
- tready=0, FIFO_DEPTH=8, send 5-beat then 5-beat frame -> first commits, second drops (cnt_drop_ovf=1); release tready -> exactly 5 beats; fifo_level goes 5 -> 0.
- SOP in RECV without EOP, then a clean 2-beat frame -> cnt_drop_err=1, only the 2-beat frame is output.
- RST_N asserted mid-frame and mid-readout -> tvalid=0 immediately; after release a fresh frame is output correctly; clr_cnt together with an EOP commit -> counters read 0.

Source files
------------

// File: rtl/cmac_lbus_rx_sf.sv
// rtl/cmac_lbus_rx_sf.sv - store-and-forward CMAC segmented RX LBUS to AXI4-Stream converter
// Frames are held until EOP; overflowed, aborted and (optionally) errored frames never reach the stream.
module cmac_lbus_rx_sf #(
  parameter int NUM_SEG    = 4,
  parameter int FIFO_DEPTH = 64,
  parameter int TS_W       = 80,
  parameter int DROP_ERR   = 1
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [NUM_SEG-1:0]          lbus_en,
  input  logic [NUM_SEG-1:0]          lbus_sop,
  input  logic [NUM_SEG-1:0]          lbus_eop,
  input  logic [NUM_SEG-1:0]          lbus_err,
  input  logic [NUM_SEG*4-1:0]        lbus_mty,
  input  logic [NUM_SEG*128-1:0]      lbus_data,
  input  logic [TS_W-1:0]             rx_timestamp,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [NUM_SEG*128-1:0]      m_axis_tdata,
  output logic [NUM_SEG*16-1:0]       m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser_err,
  output logic [TS_W-1:0]             m_axis_tuser_ts,
  input  logic                        clr_cnt,
  output logic [31:0]                 cnt_frames,
  output logic [31:0]                 cnt_drop_err,
  output logic [31:0]                 cnt_drop_ovf,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int DW = NUM_SEG * 128;
  localparam int KW = NUM_SEG * 16;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = TS_W + 2 + KW + DW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECV    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_q, wr_d, commit_q, commit_d, rd_q, base_ptr;
  logic [TS_W-1:0] ts_q, beat_ts;
  logic [31:0]     cnt_frames_q, cnt_drop_err_q, cnt_drop_ovf_q;
  logic [NUM_SEG-1:0] eop_vec;
  logic            beat_v, beat_sop, beat_eop, beat_err;
  logic            accept, full, we, load;
  logic            inc_frames, inc_ovf;
  logic [1:0]      inc_err;
  logic [DW-1:0]   beat_data;
  logic [KW-1:0]   beat_keep;
  logic [3:0]      eop_mty;
  int              eop_seg, valid_bytes;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [EW-1:0]   wr_entry, rd_entry;

  logic            tvalid_q, tlast_q, terr_q;
  logic [DW-1:0]   tdata_q;
  logic [KW-1:0]   tkeep_q;
  logic [TS_W-1:0] tts_q;

  logic unused_sop;
  assign unused_sop = ^lbus_sop;

  function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, v} + {31'd0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  assign beat_v   = lbus_en[0];
  assign beat_sop = lbus_en[0] & lbus_sop[0];
  assign eop_vec  = lbus_en & lbus_eop;
  assign beat_eop = beat_v & (|eop_vec);
  assign beat_err = |(eop_vec & lbus_err);
  assign beat_ts  = beat_sop ? rx_timestamp : ts_q;

  // LBUS puts the first byte in each segment's MSB; AXI wants it in byte lane 0.
  always_comb begin
    eop_seg = 0;
    eop_mty = 4'd0;
    for (int s = 0; s < NUM_SEG; s++) begin
      if (eop_vec[s]) begin
        eop_seg = s;
        eop_mty = lbus_mty[4*s +: 4];
      end
    end
    valid_bytes = eop_seg * 16 + 16 - int'(eop_mty);
    for (int k = 0; k < KW; k++) begin
      beat_data[8*k +: 8] = lbus_data[(k/16)*128 + 127 - 8*(k%16) -: 8];
      beat_keep[k]        = !beat_eop || (k < valid_bytes);
    end
  end

  assign wr_entry = {beat_ts, beat_err & beat_eop, beat_eop, beat_keep, beat_data};

  // A SOP always restarts from the committed point, so the overflow test uses commit_q then.
  assign base_ptr = (state_q == S_RECV && !beat_sop) ? wr_q : commit_q;
  assign full     = (base_ptr - rd_q) == PW'(FIFO_DEPTH);
  assign accept   = beat_sop || (state_q == S_RECV && beat_v);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RECV: begin
        if (accept) state_d = beat_eop ? S_IDLE : (full ? S_DISCARD : S_RECV);
      end
      S_DISCARD: begin
        if (accept)        state_d = beat_eop ? S_IDLE : (full ? S_DISCARD : S_RECV);
        else if (beat_eop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we         = 1'b0;
    wr_d       = wr_q;
    commit_d   = commit_q;
    inc_frames = 1'b0;
    inc_err    = 2'd0;
    inc_ovf    = 1'b0;
    if (state_q == S_RECV && beat_sop) begin
      wr_d    = commit_q;
      inc_err = 2'd1;
    end
    if (accept) begin
      if (full) begin
        wr_d    = commit_q;
        inc_ovf = 1'b1;
      end else begin
        we   = 1'b1;
        wr_d = base_ptr + PW'(1);
        if (beat_eop) begin
          if (beat_err && DROP_ERR != 0) begin
            wr_d    = commit_q;
            inc_err = inc_err + 2'd1;
          end else begin
            commit_d   = base_ptr + PW'(1);
            inc_frames = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_q           <= '0;
      commit_q       <= '0;
      ts_q           <= '0;
      cnt_frames_q   <= '0;
      cnt_drop_err_q <= '0;
      cnt_drop_ovf_q <= '0;
    end else begin
      wr_q     <= wr_d;
      commit_q <= commit_d;
      if (beat_sop) ts_q <= rx_timestamp;
      if (clr_cnt) begin
        cnt_frames_q   <= '0;
        cnt_drop_err_q <= '0;
        cnt_drop_ovf_q <= '0;
      end else begin
        cnt_frames_q   <= sat_add(cnt_frames_q, {1'b0, inc_frames});
        cnt_drop_err_q <= sat_add(cnt_drop_err_q, inc_err);
        cnt_drop_ovf_q <= sat_add(cnt_drop_ovf_q, {1'b0, inc_ovf});
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (we) mem[base_ptr[AW-1:0]] <= wr_entry;
  end

  assign rd_entry = mem[rd_q[AW-1:0]];
  assign load     = (rd_q != commit_q) && (!tvalid_q || m_axis_tready);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_q     <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      terr_q   <= 1'b0;
      tts_q    <= '0;
    end else if (load) begin
      rd_q     <= rd_q + PW'(1);
      tvalid_q <= 1'b1;
      tdata_q  <= rd_entry[DW-1:0];
      tkeep_q  <= rd_entry[DW +: KW];
      tlast_q  <= rd_entry[DW+KW];
      terr_q   <= rd_entry[DW+KW+1];
      tts_q    <= rd_entry[DW+KW+2 +: TS_W];
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tvalid    = tvalid_q;
  assign m_axis_tdata     = tdata_q;
  assign m_axis_tkeep     = tkeep_q;
  assign m_axis_tlast     = tlast_q;
  assign m_axis_tuser_err = terr_q;
  assign m_axis_tuser_ts  = tts_q;
  assign cnt_frames       = cnt_frames_q;
  assign cnt_drop_err     = cnt_drop_err_q;
  assign cnt_drop_ovf     = cnt_drop_ovf_q;
  assign fifo_level       = commit_q - rd_q;

endmodule
